// File: rtl/cost_mon_pkg.sv
// Shared types and constants for the epoch cost monitor.
// Optional feature macro: COST_MON_PATIENCE_EN (stall counter / early stop).
package cost_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        EVAL = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int COST_WIDTH = 32;
    localparam int COST_FRAC  = 24;
    localparam int EPOCH_W    = 16;

    localparam logic [COST_WIDTH-1:0] MAX_POS = 32'h7FFF_FFFF;

endpackage

// File: rtl/cost_mon_cnt.sv
// Per-epoch sample counter: wraps at 2^LOG2_SAMPLES and drives the
// accumulator enable so the first sample of every epoch restarts the sum.
module cost_mon_cnt #(
    parameter int LOG2_SAMPLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic active,
    input  logic inc,
    output logic tc,
    output logic acc_en
);

    logic [LOG2_SAMPLES-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc)
            cnt <= cnt + 1'b1;
    end

    assign tc     = &cnt;
    assign acc_en = active && (cnt != '0);

endmodule

// File: rtl/cost_mon.sv
// Epoch-level cost monitor: mean/best tracking plus convergence and stop flags.
// Define COST_MON_PATIENCE_EN to build the stall counter and patience stop.
module cost_mon
    import cost_mon_pkg::*;
#(
    parameter int                 WIDTH        = COST_WIDTH,
    parameter int                 FRAC         = COST_FRAC,
    parameter int                 LOG2_SAMPLES = 2,
    parameter logic [WIDTH-1:0]   THRESH       = 32'h0000_4189,
    parameter int                 PATIENCE     = 4,
    parameter logic [EPOCH_W-1:0] MAX_EPOCH    = 16'd1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic               i_valid,
    input  logic [WIDTH-1:0]   i_cost,
    output logic               o_acc_en,
    output logic               o_ready,
    output logic [WIDTH-1:0]   o_mean,
    output logic [WIDTH-1:0]   o_best,
    output logic               o_mean_valid,
    output logic [EPOCH_W-1:0] o_epoch,
    output logic               o_conv,
    output logic               o_stop,
    output logic               o_ovf
);

    localparam logic [WIDTH-1:0] MAX_P = {1'b0, {(WIDTH-1){1'b1}}};

    if (FRAC < 0 || FRAC >= WIDTH || PATIENCE < 1 || LOG2_SAMPLES < 1) begin : g_bad_cfg
        $error("cost_mon: illegal FRAC/PATIENCE/LOG2_SAMPLES configuration");
    end

    state_t state;

    logic tc;
    logic cnt_inc;

    // i_start outranks a coincident i_valid, so that sample is never counted
    assign cnt_inc = (state == RUN) && i_valid && !i_start;
    assign o_ready = (state == RUN);

    cost_mon_cnt #(
        .LOG2_SAMPLES(LOG2_SAMPLES)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (i_start),
        .active(state == RUN),
        .inc   (cnt_inc),
        .tc    (tc),
        .acc_en(o_acc_en)
    );

    logic [WIDTH-1:0]   mean_sh;
    logic               cost_neg;
    logic               better;
    logic               conv_now;
    logic               stop_now;
    logic               pat_stop;
    logic [EPOCH_W-1:0] epoch_nxt;

    assign mean_sh   = WIDTH'($signed(i_cost) >>> LOG2_SAMPLES);
    assign cost_neg  = i_cost[WIDTH-1];
    assign better    = $signed(o_mean) < $signed(o_best);
    assign epoch_nxt = o_epoch + 1'b1;
    assign conv_now  = $signed(o_mean) <= $signed(THRESH);
    assign stop_now  = pat_stop || (epoch_nxt == MAX_EPOCH);

`ifdef COST_MON_PATIENCE_EN
    localparam int SW = $clog2(PATIENCE + 1);

    logic [SW-1:0] stall;
    logic [SW-1:0] stall_nxt;

    assign stall_nxt = better ? '0 : stall + 1'b1;
    assign pat_stop  = (stall_nxt == SW'(PATIENCE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall <= '0;
        else if (i_start)
            stall <= '0;
        else if (state == EVAL)
            stall <= stall_nxt;
    end
`else
    assign pat_stop = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            o_mean       <= '0;
            o_best       <= '0;
            o_mean_valid <= 1'b0;
            o_epoch      <= '0;
            o_conv       <= 1'b0;
            o_stop       <= 1'b0;
            o_ovf        <= 1'b0;
        end else begin
            o_mean_valid <= 1'b0;
            if (i_start) begin
                state   <= RUN;
                o_epoch <= '0;
                o_best  <= MAX_P;
                o_conv  <= 1'b0;
                o_stop  <= 1'b0;
                o_ovf   <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: ;
                    RUN: begin
                        if (i_valid && tc) begin
                            // a negative sum means the accumulator wrapped
                            o_mean <= cost_neg ? MAX_P : mean_sh;
                            if (cost_neg)
                                o_ovf <= 1'b1;
                            state <= EVAL;
                        end
                    end
                    EVAL: begin
                        o_mean_valid <= 1'b1;
                        o_epoch      <= epoch_nxt;
                        if (better)
                            o_best <= o_mean;
                        if (conv_now)
                            o_conv <= 1'b1;
                        if (stop_now)
                            o_stop <= 1'b1;
                        state <= (conv_now || stop_now) ? DONE : RUN;
                    end
                    DONE: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cost_mon.sv
// Directed scoreboard bench for cost_mon (MAX_EPOCH shortened to 8).
module tb_cost_mon;
    import cost_mon_pkg::*;

    localparam logic [31:0] THR   = 32'h0000_4189;
    localparam int          PAT   = 4;
    localparam logic [15:0] MAXEP = 16'd8;
`ifdef COST_MON_PATIENCE_EN
    localparam bit PAT_EN = 1'b1;
`else
    localparam bit PAT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start, i_valid;
    logic [31:0] i_cost;
    logic        o_acc_en, o_ready, o_mean_valid, o_conv, o_stop, o_ovf;
    logic [31:0] o_mean, o_best;
    logic [15:0] o_epoch;

    cost_mon #(.MAX_EPOCH(MAXEP)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_valid(i_valid), .i_cost(i_cost),
        .o_acc_en(o_acc_en), .o_ready(o_ready), .o_mean(o_mean), .o_best(o_best),
        .o_mean_valid(o_mean_valid), .o_epoch(o_epoch), .o_conv(o_conv),
        .o_stop(o_stop), .o_ovf(o_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] mean;
        logic [31:0] best;
        logic [15:0] epoch;
        logic        conv;
        logic        stop;
        logic        ovf;
        logic        run;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    logic [31:0] m_best;
    int          m_stall;
    logic [15:0] m_epoch;
    logic        m_conv, m_stop, m_ovf, m_run;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_start();
        m_best  = MAX_POS;
        m_stall = 0;
        m_epoch = 0;
        m_conv  = 0;
        m_stop  = 0;
        m_ovf   = 0;
        m_run   = 1;
    endtask

    task automatic model_push(input logic [31:0] cost);
        exp_t e;
        logic cn, sn;
        e.mean = cost[31] ? MAX_POS : 32'($signed(cost) >>> 2);
        if (cost[31]) m_ovf = 1;
        if ($signed(e.mean) < $signed(m_best)) begin
            m_best  = e.mean;
            m_stall = 0;
        end else begin
            m_stall++;
        end
        m_epoch++;
        cn = $signed(e.mean) <= $signed(THR);
        sn = (PAT_EN && m_stall == PAT) || (m_epoch == MAXEP);
        m_conv |= cn;
        m_stop |= sn;
        m_run  = !(cn || sn);
        e.best  = m_best;
        e.epoch = m_epoch;
        e.conv  = m_conv;
        e.stop  = m_stop;
        e.ovf   = m_ovf;
        e.run   = m_run;
        sb.push_back(e);
    endtask

    task automatic do_start();
        i_start = 1;
        tick();
        i_start = 0;
        model_start();
        chk("start_ready", o_ready, 1);
        chk("start_acc_en", o_acc_en, 0);
        chk("start_best", o_best, MAX_POS);
        chk("start_epoch", o_epoch, 0);
        chk("start_flags", {o_conv, o_stop, o_ovf}, 0);
    endtask

    // One epoch of four back-to-back samples; i_valid stays high through EVAL
    task automatic epoch(input logic [31:0] last);
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            i_valid = 1;
            i_cost  = (k == 3) ? last : 32'h0000_1000 * k;
            chk("acc_en", o_acc_en, (k != 0));
            if (k == 3) model_push(last);
            tick();
        end
        i_cost = 32'h1234_5678;
        chk("eval_ready", o_ready, 0);
        chk("eval_acc_en", o_acc_en, 0);
        chk("eval_mean", o_mean, sb[0].mean);
        tick();
        i_valid = 0;
        for (int w = 0; w < 3 && !o_mean_valid; w++) tick();
        chk("mean_valid", o_mean_valid, 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("mean", o_mean, e.mean);
            chk("best", o_best, e.best);
            chk("epoch", o_epoch, e.epoch);
            chk("conv", o_conv, e.conv);
            chk("stop", o_stop, e.stop);
            chk("ovf", o_ovf, e.ovf);
            chk("ready_after", o_ready, e.run);
        end
        tick();
        chk("mv_pulse", o_mean_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1; i_start = 0; i_valid = 0; i_cost = '0;
        repeat (2) tick();
        chk("rst_ready", o_ready, 0);
        chk("rst_acc_en", o_acc_en, 0);
        chk("rst_mean", o_mean, 0);
        chk("rst_best", o_best, 0);
        chk("rst_epoch", o_epoch, 0);
        chk("rst_flags", {o_mean_valid, o_conv, o_stop, o_ovf}, 0);
        rst = 0;
        tick();
        chk("idle_ready", o_ready, 0);

        // mean/best then patience or MAX_EPOCH stop on a flat cost
        do_start();
        epoch(32'h0400_0000);
        chk("best_1p0", o_best, 32'h0100_0000);
        for (int e = 2; e <= 8 && m_run; e++) epoch(32'h0400_0000);
        chk("stop_end", o_stop, 1);
        chk("stop_epoch", o_epoch, PAT_EN ? 16'd5 : 16'd8);
        chk("stop_noconv", o_conv, 0);
        chk("done_acc_en", o_acc_en, 0);

        // overflow keeps best, sticky ovf, then convergence
        do_start();
        epoch(32'h8000_0000);
        epoch(32'h0400_0000);
        epoch(32'h8000_0000);
        chk("ovf_best_kept", o_best, 32'h0100_0000);
        epoch(32'h0000_8000);
        chk("conv_mean", o_mean, 32'h0000_2000);
        for (int k = 0; k < 4; k++) begin
            i_valid = 1;
            i_cost  = 32'h0000_0004;
            tick();
            chk("done_hold_mv", o_mean_valid, 0);
        end
        i_valid = 0;
        chk("done_hold_epoch", o_epoch, 4);
        chk("done_hold_ready", o_ready, 0);

        // threshold boundary with truncation: 0x10628>>2 above, 0x10627>>2 equal
        do_start();
        epoch(32'h0001_0628);
        epoch(32'h0001_0627);
        chk("thr_eq_conv", o_conv, 1);

        // reset mid-epoch, then start racing a sample
        do_start();
        for (int k = 0; k < 2; k++) begin
            i_valid = 1;
            i_cost  = 32'h0000_0100;
            tick();
        end
        i_valid = 0;
        rst = 1;
        #1;
        chk("mid_rst_ready", o_ready, 0);
        chk("mid_rst_best", o_best, 0);
        chk("mid_rst_mean", o_mean, 0);
        chk("mid_rst_epoch", o_epoch, 0);
        tick();
        rst = 0;
        i_start = 1;
        i_valid = 1;
        tick();
        i_start = 0;
        i_valid = 0;
        model_start();
        chk("race_ready", o_ready, 1);
        chk("race_acc_en", o_acc_en, 0);
        epoch(32'h0200_0000);
        chk("race_best", o_best, 32'h0080_0000);

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
